ext_pipe: RTL and testbench
===========================

# ext_pipe

Parametrised, elastic sign/zero-extension stage for the multi-cycle datapath. It widens an IN_W-bit immediate or load field to OUT_W bits in one of four modes, and registers the result in a 2-entry FIFO with valid/ready handshakes on both sides. It sits between decode/load-align and the ALU operand mux. It supersedes the fixed 16-to-32 combinational extender wherever back-pressure or a registered boundary is needed.

## Interface
- IN_W, 16, input field width; legal range 2 ≤ IN_W < OUT_W
- OUT_W, 32, output width
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a field on in_data/in_mode
- in_ready  output  1  block can accept this cycle
- in_data  input  IN_W  field to extend
- in_mode  input  2  00 zero-ext, 01 sign-ext, 10 high-place, 11 ones-ext
- out_valid  output  1  out_data holds a valid result
- out_ready  input  1  consumer takes out_data this cycle
- out_data  output  OUT_W  extended result, oldest first
- ext_cnt  output  16  completed-transfer count (only with EXT_CNT_EN)

## Operation
- Mode 00: out = {(OUT_W-IN_W) zeros, in_data}.
- Mode 01: out = {(OUT_W-IN_W) copies of in_data[IN_W-1], in_data}.
- Mode 10: out = {in_data, (OUT_W-IN_W) zeros}, i.e. lui-style placement.
- Mode 11: out = {(OUT_W-IN_W) ones, in_data}.
- Extension is computed combinationally at the input. The OUT_W result is written into the FIFO on acceptance. in_mode is not stored.
- Accept: in_valid & in_ready at a rising edge. Release: out_valid & out_ready at a rising edge.
- FIFO: 2 entries, occupancy count 0..2, strict in-order.
  - in_ready = (count < 2). It depends only on registered state; there is no combinational path from out_ready.
  - out_valid = (count > 0).
  - out_data = head entry. It is held stable while out_valid & !out_ready.
- Occupancy update:
  - Accept without release: count+1.
  - Release without accept: count-1.
  - Both at once (only possible at count = 1): count stays 1; the head is replaced by the new entry.
- Full (count = 2): in_ready = 0. A same-cycle release does not admit a new entry; the producer retries next cycle.
- Empty (count = 0): out_valid = 0. out_data is don't-care but must not contain X after reset; it reads 0.
- Read/write pointers are 1 bit each and wrap 1→0.
- Producer rule: a producer holding in_valid while in_ready = 0 keeps in_data/in_mode stable. The block does not check this.

## Timing
- Latency: a field accepted at edge N is presented with out_valid = 1 from edge N until released (1-cycle latency).
- Throughput: 1 transfer/cycle sustained when out_ready is held high.
- Reset (rst_n low, asynchronous, any time): count = 0, pointers = 0, storage = 0, out_valid = 0, out_data = 0, in_ready = 1, ext_cnt = 0. Entries in flight are discarded, not drained.
- Reset release: the first acceptance can occur at the first rising edge with rst_n high.
- No output is driven directly from a combinational path from any input.

## Configuration
- Macro: EXT_CNT_EN.
- Defined:
  - ext_cnt increments by 1 on every release and wraps from 0xFFFF to 0x0000.
  - It resets to 0 and is readable every cycle.
- Undefined: the ext_cnt port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset mid-flight:
  - Stimulus: count = 2, then rst_n asserted low for 1 cycle.
  - Required: out_valid = 0, in_ready = 1, out_data = 0 immediately (asynchronous); ext_cnt = 0; old entries never appear after release.
- Mode sweep, IN_W = 16, OUT_W = 32, out_ready = 1:
  - 0x8001 in mode 00 → 0x00008001.
  - 0x8001 in mode 01 → 0xFFFF8001.
  - 0x8001 in mode 10 → 0x80010000.
  - 0x0001 in mode 11 → 0xFFFF0001.
  - 0x7FFF in mode 01 → 0x00007FFF.
- Back-pressure:
  - Stimulus: out_ready = 0; offer 0x0001, 0x0002, 0x0003 in mode 00 on consecutive cycles; then set out_ready = 1.
  - Required: in_ready drops to 0 after two accepts; 0x0003 is held by the producer; outputs arrive in order 1, 2, 3 with no loss or duplicate.
- Simultaneous accept/release:
  - Stimulus: count = 1, in_valid = 1, out_ready = 1 for 10 cycles.
  - Required: count stays 1 and one output per cycle in order.
  - Stimulus: count = 2 with release.
  - Required: no accept that cycle.
- Parameter corner:
  - Stimulus: IN_W = 8, OUT_W = 12; input 0x80.
  - Required: mode 01 → 0xF80; mode 10 → 0x800.
- Counter wrap (EXT_CNT_EN defined):
  - Stimulus: 65537 releases.
  - Required: ext_cnt = 1; with out_ready held low, ext_cnt does not move.

Source files
------------

// File: rtl/ext_pipe.sv
// Elastic sign/zero-extension stage: widens IN_W to OUT_W in one of four modes into a 2-entry FIFO.
// Optional completed-transfer counter on ext_cnt when EXT_CNT_EN is defined.
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef EXT_CNT_EN
    ,
    output logic [15:0]      ext_cnt
`endif
);

    localparam int PAD = OUT_W - IN_W;

    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // in_ready depends only on occupancy, never on out_ready.
    logic [OUT_W-1:0] ext_val;
    logic [OUT_W-1:0] mem [2];
    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_accept;
    logic             do_release;

    always_comb begin
        ext_val = '0;
        case (in_mode)
            2'b00:   ext_val = {{PAD{1'b0}}, in_data};
            2'b01:   ext_val = {{PAD{in_data[IN_W-1]}}, in_data};
            2'b10:   ext_val = {in_data, {PAD{1'b0}}};
            default: ext_val = {{PAD{1'b1}}, in_data};
        endcase
    end

    assign in_ready   = (count < 2'd2);
    assign out_valid  = (count != 2'd0);
    assign out_data   = mem[rd_ptr];
    assign do_accept  = in_valid & in_ready;
    assign do_release = out_valid & out_ready;

    // At count = 1 a simultaneous write lands in the other slot, which becomes the new head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_accept) begin
                mem[wr_ptr] <= ext_val;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_release) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_accept && !do_release) begin
                count <= count + 2'd1;
            end else if (!do_accept && do_release) begin
                count <= count - 2'd1;
            end
        end
    end

`ifdef EXT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_cnt <= 16'd0;
        end else if (do_release) begin
            ext_cnt <= ext_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: a 16->32 instance and an 8->12 corner instance.
// Counter checks are compiled in when EXT_CNT_EN is defined.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
`ifdef EXT_CNT_EN
    logic [15:0] ext_cnt;
    logic [15:0] rel_cnt = '0;
`endif

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [7:0]  s_in_data = '0;
    logic [1:0]  s_in_mode = '0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic [11:0] s_out_data;
`ifdef EXT_CNT_EN
    logic [15:0] s_ext_cnt;
`endif

    logic [31:0] exp_q[$];
    logic [11:0] exp_s_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef EXT_CNT_EN
        , .ext_cnt(ext_cnt)
`endif
    );

    ext_pipe #(.IN_W(8), .OUT_W(12)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_mode(s_in_mode),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data)
`ifdef EXT_CNT_EN
        , .ext_cnt(s_ext_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Holds the field until accepted; the expected result is queued on the accepting cycle.
    task automatic send(input logic [15:0] d, input logic [1:0] m, input logic [31:0] e);
        int guard;
        bit done;
        guard = 0;
        done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end else begin
                guard++;
                if (guard > 200) begin
                    check("accept_timeout", 32'(guard), 32'd0);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_s(input logic [7:0] d, input logic [1:0] m, input logic [11:0] e);
        int guard;
        bit done;
        guard = 0;
        done = 0;
        s_in_valid = 1'b1;
        s_in_data  = d;
        s_in_mode  = m;
        while (!done) begin
            @(negedge clk);
            if (s_in_ready) begin
                exp_s_q.push_back(e);
                done = 1;
            end else begin
                guard++;
                if (guard > 200) begin
                    check("accept_s_timeout", 32'(guard), 32'd0);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
    endtask

    // Monitor: a release occurs on the following rising edge, so compare the head now.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", out_data, 32'hDEAD_BEEF);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
`ifdef EXT_CNT_EN
            check("ext_cnt_track", {16'd0, ext_cnt}, {16'd0, rel_cnt});
            rel_cnt = rel_cnt + 16'd1;
`endif
        end
`ifdef EXT_CNT_EN
        if (!rst_n) rel_cnt = '0;
`endif
    end

    always @(negedge clk) begin
        if (rst_n && s_out_valid && s_out_ready) begin
            if (exp_s_q.size() == 0) begin
                check("unexpected_out_s", {20'd0, s_out_data}, 32'hDEAD_BEEF);
            end else begin
                check("out_data_s", {20'd0, s_out_data}, {20'd0, exp_s_q.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        check("global_timeout", 32'd1, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_data",  out_data,           32'd0);
        check("rst_out_data_s", {20'd0, s_out_data}, 32'd0);
`ifdef EXT_CNT_EN
        check("rst_ext_cnt", {16'd0, ext_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mode sweep with a free-running consumer
        out_ready = 1'b1;
        send(16'h8001, 2'b00, 32'h0000_8001);
        send(16'h8001, 2'b01, 32'hFFFF_8001);
        send(16'h8001, 2'b10, 32'h8001_0000);
        send(16'h0001, 2'b11, 32'hFFFF_0001);
        send(16'h7FFF, 2'b01, 32'h0000_7FFF);
        send(16'h1234, 2'b10, 32'h1234_0000);
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure: third field is held until a slot frees up
        out_ready = 1'b0;
        fork
            begin
                send(16'h0001, 2'b00, 32'h0000_0001);
                send(16'h0002, 2'b00, 32'h0000_0002);
                send(16'h0003, 2'b00, 32'h0000_0003);
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
                check("bp_head_held", out_data, 32'h0000_0001);
                repeat (2) @(negedge clk);
                check("bp_head_stable", out_data, 32'h0000_0001);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                // Full with a release pending: still no admission this cycle
                @(negedge clk);
                check("full_release_no_accept", {31'd0, in_ready}, 32'd0);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Simultaneous accept/release at count = 1
        out_ready = 1'b0;
        send(16'hA5A5, 2'b01, 32'hFFFF_A5A5);
        out_ready = 1'b1;
        fork
            begin
                send(16'h0010, 2'b00, 32'h0000_0010);
                send(16'h8010, 2'b01, 32'hFFFF_8010);
                send(16'h0011, 2'b10, 32'h0011_0000);
                send(16'h0012, 2'b11, 32'hFFFF_0012);
                send(16'hFFFF, 2'b00, 32'h0000_FFFF);
                send(16'hFFFF, 2'b01, 32'hFFFF_FFFF);
                send(16'hFFFF, 2'b10, 32'hFFFF_0000);
                send(16'h0000, 2'b11, 32'hFFFF_0000);
                send(16'h4000, 2'b01, 32'h0000_4000);
                send(16'hC000, 2'b01, 32'hFFFF_C000);
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("sim_count1_valid", {31'd0, out_valid}, 32'd1);
                    check("sim_count1_ready", {31'd0, in_ready},  32'd1);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("sim_drained", 32'(exp_q.size()), 32'd0);

        // Parameter corner on the 8->12 instance
        send_s(8'h80, 2'b01, 12'hF80);
        send_s(8'h80, 2'b10, 12'h800);
        send_s(8'h80, 2'b00, 12'h080);
        send_s(8'h7F, 2'b11, 12'hF7F);
        send_s(8'h7F, 2'b01, 12'h07F);
        repeat (3) @(posedge clk);
        #1;
        check("s_drained", 32'(exp_s_q.size()), 32'd0);

        // Reset mid-flight with two entries stored
        out_ready = 1'b0;
        send(16'hBEEF, 2'b00, 32'h0000_BEEF);
        send(16'hCAFE, 2'b00, 32'h0000_CAFE);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("mid_rst_out_data",  out_data,           32'd0);
`ifdef EXT_CNT_EN
        check("mid_rst_ext_cnt", {16'd0, ext_cnt}, 32'd0);
`endif
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0042, 2'b01, 32'h0000_0042);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);
        check("post_rst_empty", {31'd0, out_valid}, 32'd0);

`ifdef EXT_CNT_EN
        // Counter wrap: 65537 releases from reset leave ext_cnt at 1
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 65537; i++) begin
            send(16'(i), 2'b00, {16'd0, 16'(i)});
        end
        repeat (3) @(posedge clk);
        #1;
        check("cnt_wrap", {16'd0, ext_cnt}, 32'd1);
        out_ready = 1'b0;
        send(16'h0077, 2'b00, 32'h0000_0077);
        repeat (5) @(posedge clk);
        #1;
        check("cnt_hold", {16'd0, ext_cnt}, 32'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("cnt_after_hold", {16'd0, ext_cnt}, 32'd2);
`endif

        check("final_q_empty", 32'(exp_q.size() + exp_s_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
